// File: rtl/axi_strided_rd_engine.sv
// Strided AXI4 read engine: expands one LSU load command into N bursts at base + n*stride,
// tracks up to MAX_OUT bursts by ARID and forwards R beats tagged with their burst index.
module axi_strided_rd_engine #(
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_stride,
  input  logic [CNT_W-1:0]  cmd_num,
  input  logic [7:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic [3:0]        ARREGION,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic              rd_vld,
  input  logic              rd_rdy,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        rd_resp,
  output logic              rd_last,
  output logic [CNT_W-1:0]  rd_idx,
  output logic              busy,
  output logic              done,
  output logic              done_err
);
  localparam int NSLOT = 1 << ID_W;
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t            state;
  logic [ADDR_W-1:0] stride;
  logic [ADDR_W-1:0] issue_addr;
  logic [CNT_W-1:0]  num;
  logic [CNT_W-1:0]  issue_cnt;
  logic [7:0]        len;
  logic [2:0]        size;
  logic [1:0]        burst;
  logic [ID_W-1:0]   arid;
  logic [OUT_W-1:0]  outstanding;
  logic              err;
  logic [NSLOT-1:0]  slot_busy;
  logic [CNT_W-1:0]  slot_idx [NSLOT];

  logic ar_hs, r_hs, r_hit, rl_hs, err_set;

  assign ARID     = arid;
  assign ARADDR   = issue_addr;
  assign ARLEN    = len;
  assign ARSIZE   = size;
  assign ARBURST  = burst;
  assign ARREGION = 4'd0;
  assign cmd_rdy  = (state == IDLE);
  assign busy     = (state != IDLE);
  assign RREADY   = ~rd_vld | rd_rdy;

  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID & RREADY;
  assign r_hit = r_hs & slot_busy[RID];
  assign rl_hs = r_hit & RLAST;
  // Beats outside a command are silently dropped; inside one, stray RIDs and bad RRESP flag the command.
  assign err_set = (state != IDLE) & r_hs & (~slot_busy[RID] | (RRESP != 2'b00));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      stride      <= {ADDR_W{1'b0}};
      issue_addr  <= {ADDR_W{1'b0}};
      num         <= {CNT_W{1'b0}};
      issue_cnt   <= {CNT_W{1'b0}};
      len         <= 8'd0;
      size        <= 3'd0;
      burst       <= 2'd0;
      arid        <= {ID_W{1'b0}};
      outstanding <= {OUT_W{1'b0}};
      err         <= 1'b0;
      slot_busy   <= {NSLOT{1'b0}};
      for (int i = 0; i < NSLOT; i++) slot_idx[i] <= {CNT_W{1'b0}};
      ARVALID     <= 1'b0;
      rd_vld      <= 1'b0;
      rd_data     <= {DATA_W{1'b0}};
      rd_resp     <= 2'b00;
      rd_last     <= 1'b0;
      rd_idx      <= {CNT_W{1'b0}};
      done        <= 1'b0;
      done_err    <= 1'b0;
    end else begin
      // The AR set is written after the RLAST free so it wins on a shared slot.
      if (rl_hs) slot_busy[RID] <= 1'b0;
      if (ar_hs) begin
        slot_busy[arid] <= 1'b1;
        slot_idx[arid]  <= issue_cnt;
      end

      case ({ar_hs, rl_hs})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase

      if (r_hit) begin
        rd_vld  <= 1'b1;
        rd_data <= RDATA;
        rd_resp <= RRESP;
        rd_last <= RLAST;
        rd_idx  <= slot_idx[RID];
      end else if (rd_rdy) begin
        rd_vld <= 1'b0;
      end else begin
        rd_vld <= rd_vld;
      end

      if (err_set) err <= 1'b1;

      done     <= 1'b0;
      done_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_vld) begin
            stride     <= cmd_stride;
            issue_addr <= cmd_addr;
            num        <= cmd_num;
            len        <= cmd_len;
            size       <= cmd_size;
            burst      <= cmd_burst;
            issue_cnt  <= {CNT_W{1'b0}};
            arid       <= {ID_W{1'b0}};
            err        <= 1'b0;
            if (cmd_num == {CNT_W{1'b0}}) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // AR fields are held until the handshake, then advance to the next burst.
          if (ar_hs) begin
            ARVALID    <= 1'b0;
            issue_cnt  <= issue_cnt + CNT_W'(1);
            issue_addr <= issue_addr + stride;
            arid       <= arid + ID_W'(1);
          end else if (!ARVALID && issue_cnt == num) begin
            state <= DRAIN;
          end else if (!ARVALID && issue_cnt < num && outstanding < OUT_W'(MAX_OUT) &&
                       !slot_busy[arid]) begin
            ARVALID <= 1'b1;
          end else begin
            ARVALID <= ARVALID;
          end
        end
        DRAIN: begin
          if (outstanding == {OUT_W{1'b0}} && !rd_vld) begin
            state    <= DONE;
            done     <= 1'b1;
            done_err <= err | err_set;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_strided_rd_engine.sv
// Directed bench: dut (MAX_OUT=8) covers the main flows; dut_b (MAX_OUT=2) covers the outstanding limit.
module tb_axi_strided_rd_engine;
  logic clk, rst;
  logic [31:0] cmd_addr, cmd_stride;
  logic [7:0] cmd_num, cmd_len;
  logic [2:0] cmd_size;
  logic [1:0] cmd_burst;
  logic [63:0] RDATA;
  logic [1:0] RRESP;

  logic cmd_vld, cmd_rdy, ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic rd_vld, rd_rdy, rd_last, busy, done, done_err;
  logic [3:0] ARID, ARREGION, RID;
  logic [31:0] ARADDR;
  logic [7:0] ARLEN, rd_idx;
  logic [2:0] ARSIZE;
  logic [1:0] ARBURST, rd_resp;
  logic [63:0] rd_data;

  logic b_cmd_vld, b_cmd_rdy, b_ARVALID, b_ARREADY, b_RLAST, b_RVALID, b_RREADY;
  logic b_rd_vld, b_rd_rdy, b_rd_last, b_busy, b_done, b_done_err;
  logic [3:0] b_ARID, b_ARREGION, b_RID;
  logic [31:0] b_ARADDR;
  logic [7:0] b_ARLEN, b_rd_idx;
  logic [2:0] b_ARSIZE;
  logic [1:0] b_ARBURST, b_rd_resp;
  logic [63:0] b_rd_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] ar_addr [8];
  logic [3:0]  ar_id [8];
  logic [7:0]  ar_len [8];
  int ar_cnt;

  axi_strided_rd_engine #(.ID_W(4), .ADDR_W(32), .DATA_W(64), .MAX_OUT(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr),
    .cmd_stride(cmd_stride), .cmd_num(cmd_num), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .cmd_burst(cmd_burst), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last),
    .rd_idx(rd_idx), .busy(busy), .done(done), .done_err(done_err));

  axi_strided_rd_engine #(.ID_W(4), .ADDR_W(32), .DATA_W(64), .MAX_OUT(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .cmd_vld(b_cmd_vld), .cmd_rdy(b_cmd_rdy), .cmd_addr(cmd_addr),
    .cmd_stride(cmd_stride), .cmd_num(cmd_num), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .cmd_burst(cmd_burst), .ARID(b_ARID), .ARADDR(b_ARADDR), .ARLEN(b_ARLEN), .ARSIZE(b_ARSIZE),
    .ARBURST(b_ARBURST), .ARREGION(b_ARREGION), .ARVALID(b_ARVALID), .ARREADY(b_ARREADY),
    .RID(b_RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(b_RLAST), .RVALID(b_RVALID),
    .RREADY(b_RREADY), .rd_vld(b_rd_vld), .rd_rdy(b_rd_rdy), .rd_data(b_rd_data),
    .rd_resp(b_rd_resp), .rd_last(b_rd_last), .rd_idx(b_rd_idx), .busy(b_busy), .done(b_done),
    .done_err(b_done_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] s, input logic [7:0] n,
                          input logic [7:0] l);
    for (int c = 0; c < 10 && !cmd_rdy; c++) tick();
    cmd_addr = a; cmd_stride = s; cmd_num = n; cmd_len = l;
    cmd_vld = 1'b1;
    tick();
    cmd_vld = 1'b0;
  endtask

  task automatic collect_ars(input int n);
    ar_cnt = 0;
    for (int c = 0; c < 100 && ar_cnt < n; c++) begin
      if (ARVALID && ARREADY) begin
        ar_addr[ar_cnt] = ARADDR; ar_id[ar_cnt] = ARID; ar_len[ar_cnt] = ARLEN;
        ar_cnt++;
      end
      tick();
    end
  endtask

  task automatic send_beat(input logic [3:0] id, input logic [63:0] d, input logic [1:0] resp,
                           input logic last);
    RID = id; RDATA = d; RRESP = resp; RLAST = last; RVALID = 1'b1;
    tick();
    RVALID = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output bit err);
    seen = 1'b0; err = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin seen = 1'b1; err = done_err; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_cmd_rdy: got %b want 1", cmd_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ARVALID !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", ARVALID); end
    checks++; if ({rd_vld, done, done_err} !== 3'b000) begin errors++; $display("FAIL reset_rd_done: got %b want 000", {rd_vld, done, done_err}); end
    checks++; if (ARREGION !== 4'd0) begin errors++; $display("FAIL reset_arregion: got %h want 0", ARREGION); end
    rst = 1'b0;
    tick();
    checks++; if (b_cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_b_cmd_rdy: got %b want 1", b_cmd_rdy); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_addr [3];
    logic [63:0] exp_d;
    exp_addr[0] = 32'h100; exp_addr[1] = 32'h140; exp_addr[2] = 32'h180;
    send_cmd(32'h100, 32'h40, 8'd3, 8'd1);
    collect_ars(3);
    checks++; if (ar_cnt !== 3) begin errors++; $display("FAIL basic_ar_count: got %0d want 3", ar_cnt); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (ar_addr[k] !== exp_addr[k]) begin errors++; $display("FAIL basic_araddr%0d: got %h want %h", k, ar_addr[k], exp_addr[k]); end
      checks++; if (ar_id[k] !== 4'(k)) begin errors++; $display("FAIL basic_arid%0d: got %0d want %0d", k, ar_id[k], k); end
      checks++; if (ar_len[k] !== 8'd1) begin errors++; $display("FAIL basic_arlen%0d: got %0d want 1", k, ar_len[k]); end
    end
    rd_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < 2; b++) begin
        exp_d = 64'hA5A5_0000_0000_0000 + 64'(k * 16 + b);
        send_beat(4'(k), exp_d, 2'b00, (b == 1));
        checks++; if (rd_vld !== 1'b1) begin errors++; $display("FAIL basic_rd_vld%0d%0d: got %b want 1", k, b, rd_vld); end
        checks++; if (rd_idx !== 8'(k)) begin errors++; $display("FAIL basic_rd_idx%0d%0d: got %0d want %0d", k, b, rd_idx, k); end
        checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL basic_rd_data%0d%0d: got %h want %h", k, b, rd_data, exp_d); end
        checks++; if (rd_last !== (b == 1)) begin errors++; $display("FAIL basic_rd_last%0d%0d: got %b want %b", k, b, rd_last, (b == 1)); end
      end
    end
    tick();
    checks++; if ({rd_vld, done} !== 2'b00) begin errors++; $display("FAIL basic_accept: got vld,done=%b want 00", {rd_vld, done}); end
    tick();
    checks++; if ({done, done_err} !== 2'b10) begin errors++; $display("FAIL basic_done: got done,err=%b want 10", {done, done_err}); end
    tick();
    checks++; if ({done, cmd_rdy} !== 2'b01) begin errors++; $display("FAIL basic_done_pulse: got done,rdy=%b want 01", {done, cmd_rdy}); end
  endtask

  task automatic test_out_of_order();
    logic [3:0] order [4];
    int dcount;
    order[0] = 4'd3; order[1] = 4'd1; order[2] = 4'd0; order[3] = 4'd2;
    send_cmd(32'h2000, 32'h10, 8'd4, 8'd0);
    collect_ars(4);
    checks++; if (ar_cnt !== 4 || ar_id[3] !== 4'd3) begin errors++; $display("FAIL ooo_ar: got cnt %0d id3 %0d want 4,3", ar_cnt, ar_id[3]); end
    rd_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_beat(order[k], 64'hB000 + 64'(order[k]), 2'b00, 1'b1);
      checks++; if (rd_idx !== 8'(order[k]) || rd_vld !== 1'b1) begin errors++; $display("FAIL ooo_idx%0d: got %0d vld %b want %0d", k, rd_idx, rd_vld, order[k]); end
      checks++; if (rd_data !== 64'hB000 + 64'(order[k])) begin errors++; $display("FAIL ooo_data%0d: got %h want %h", k, rd_data, 64'hB000 + 64'(order[k])); end
    end
    dcount = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done) dcount++;
    end
    checks++; if (dcount !== 1) begin errors++; $display("FAIL ooo_done_count: got %0d want 1", dcount); end
  endtask

  task automatic test_limit();
    int hs;
    bit found;
    cmd_addr = 32'h300; cmd_stride = 32'h20; cmd_num = 8'd3; cmd_len = 8'd0;
    b_cmd_vld = 1'b1;
    tick();
    b_cmd_vld = 1'b0;
    hs = 0;
    for (int c = 0; c < 16; c++) begin
      if (b_ARVALID && b_ARREADY) hs++;
      tick();
    end
    checks++; if (hs !== 2) begin errors++; $display("FAIL limit_ar_count: got %0d want 2", hs); end
    checks++; if (b_ARVALID !== 1'b0) begin errors++; $display("FAIL limit_arvalid_low: got %b want 0", b_ARVALID); end
    b_rd_rdy = 1'b1; b_RID = 4'd0; b_RLAST = 1'b1; b_RVALID = 1'b1; RRESP = 2'b00;
    tick();
    b_RVALID = 1'b0;
    checks++; if (b_rd_vld !== 1'b1 || b_rd_idx !== 8'd0) begin errors++; $display("FAIL limit_beat0: got vld %b idx %0d want 1,0", b_rd_vld, b_rd_idx); end
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (b_ARVALID) begin found = 1'b1; break; end
      tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL limit_third_ar: got no ARVALID want ARVALID within 10 cycles"); end
    checks++; if (b_ARID !== 4'd2 || b_ARADDR !== 32'h340) begin errors++; $display("FAIL limit_third_arid: got id %0d addr %h want 2,340", b_ARID, b_ARADDR); end
    tick();
    b_rd_rdy = 1'b0; b_RID = 4'd1; b_RVALID = 1'b1;
    tick();
    checks++; if (b_rd_vld !== 1'b1 || b_rd_idx !== 8'd1) begin errors++; $display("FAIL limit_beat1: got vld %b idx %0d want 1,1", b_rd_vld, b_rd_idx); end
    checks++; if (b_RREADY !== 1'b0) begin errors++; $display("FAIL limit_rready_low: got %b want 0", b_RREADY); end
    b_RID = 4'd2;
    tick();
    checks++; if (b_rd_idx !== 8'd1 || b_rd_vld !== 1'b1) begin errors++; $display("FAIL limit_hold: got idx %0d vld %b want 1,1", b_rd_idx, b_rd_vld); end
    b_rd_rdy = 1'b1;
    tick();
    b_RVALID = 1'b0;
    checks++; if (b_rd_idx !== 8'd2) begin errors++; $display("FAIL limit_beat2: got idx %0d want 2", b_rd_idx); end
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (b_done) begin found = 1'b1; break; end
      tick();
    end
    checks++; if (!found || b_done_err !== 1'b0) begin errors++; $display("FAIL limit_done: got seen %b err %b want 1,0", found, b_done_err); end
    tick();
  endtask

  task automatic test_errors();
    bit seen, err, arv;
    rd_rdy = 1'b1;
    send_cmd(32'h800, 32'h40, 8'd1, 8'd0);
    collect_ars(1);
    send_beat(4'd0, 64'h1, 2'b10, 1'b1);
    checks++; if (rd_resp !== 2'b10) begin errors++; $display("FAIL err_rd_resp: got %b want 10", rd_resp); end
    wait_done(seen, err);
    checks++; if ({seen, err} !== 2'b11) begin errors++; $display("FAIL err_rresp_done: got seen,err=%b want 11", {seen, err}); end

    send_cmd(32'h900, 32'h40, 8'd1, 8'd0);
    collect_ars(1);
    RID = 4'd5; RVALID = 1'b1;
    checks++; if (RREADY !== 1'b1) begin errors++; $display("FAIL err_unknown_rready: got %b want 1", RREADY); end
    send_beat(4'd5, 64'h2, 2'b00, 1'b1);
    checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL err_unknown_drop: got rd_vld %b want 0", rd_vld); end
    send_beat(4'd0, 64'h3, 2'b00, 1'b1);
    wait_done(seen, err);
    checks++; if ({seen, err} !== 2'b11) begin errors++; $display("FAIL err_unknown_done: got seen,err=%b want 11", {seen, err}); end

    send_cmd(32'hA00, 32'h40, 8'd0, 8'd0);
    seen = 1'b0; arv = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (done) seen = 1'b1;
      if (ARVALID) arv = 1'b1;
      tick();
    end
    checks++; if ({seen, arv} !== 2'b10) begin errors++; $display("FAIL err_num0: got done,arvalid=%b want 10", {seen, arv}); end

    send_cmd(32'hFFFF_FFC0, 32'h40, 8'd2, 8'd0);
    collect_ars(2);
    checks++; if (ar_addr[0] !== 32'hFFFF_FFC0 || ar_addr[1] !== 32'h0) begin errors++; $display("FAIL err_wrap: got %h,%h want ffffffc0,0", ar_addr[0], ar_addr[1]); end
    send_beat(4'd0, 64'h4, 2'b00, 1'b1);
    send_beat(4'd1, 64'h5, 2'b00, 1'b1);
    wait_done(seen, err);
    checks++; if ({seen, err} !== 2'b10) begin errors++; $display("FAIL err_wrap_done: got seen,err=%b want 10", {seen, err}); end
    tick();

    send_beat(4'd3, 64'h6, 2'b00, 1'b1);
    checks++; if ({rd_vld, done, cmd_rdy} !== 3'b001) begin errors++; $display("FAIL err_idle_beat: got vld,done,rdy=%b want 001", {rd_vld, done, cmd_rdy}); end
  endtask

  task automatic test_reset_mid();
    bit seen, err;
    send_cmd(32'h400, 32'h10, 8'd5, 8'd0);
    collect_ars(3);
    checks++; if (ar_cnt !== 3 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_setup: got cnt %0d busy %b want 3,1", ar_cnt, busy); end
    rst = 1'b1;
    tick();
    checks++; if ({ARVALID, rd_vld, busy, cmd_rdy} !== 4'b0001) begin errors++; $display("FAIL rstmid_state: got arv,vld,busy,rdy=%b want 0001", {ARVALID, rd_vld, busy, cmd_rdy}); end
    rst = 1'b0;
    send_cmd(32'h500, 32'h10, 8'd1, 8'd0);
    collect_ars(1);
    checks++; if (ar_cnt !== 1 || ar_id[0] !== 4'd0 || ar_addr[0] !== 32'h500) begin errors++; $display("FAIL rstmid_arid: got cnt %0d id %0d addr %h want 1,0,500", ar_cnt, ar_id[0], ar_addr[0]); end
    send_beat(4'd0, 64'h7, 2'b00, 1'b1);
    wait_done(seen, err);
    checks++; if ({seen, err} !== 2'b10) begin errors++; $display("FAIL rstmid_done: got seen,err=%b want 10", {seen, err}); end
  endtask

  initial begin
    rst = 1'b1; cmd_vld = 1'b0; b_cmd_vld = 1'b0;
    cmd_addr = 32'h0; cmd_stride = 32'h0; cmd_num = 8'd0; cmd_len = 8'd0;
    cmd_size = 3'd3; cmd_burst = 2'b01;
    ARREADY = 1'b1; RID = 4'd0; RDATA = 64'h0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
    rd_rdy = 1'b1;
    b_ARREADY = 1'b1; b_RID = 4'd0; b_RLAST = 1'b0; b_RVALID = 1'b0; b_rd_rdy = 1'b1;
    test_reset();
    test_basic();
    test_out_of_order();
    test_limit();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
